seq_halt_controller: RTL
========================

// Module: seq_halt_controller
// PURPOSE
//  Consumer of the 2-bit processor status word produced by the SEQ status-update logic. Gates
//  architectural commits (PC, register file, memory writes) while status is AOK. Freezes the
//  machine on HLT/ADR/INS and captures the faulting PC. Reports a halt/done handshake to the
//  testbench/top. Sits between status update and the PC-update/writeback enables.
// PARAMETERS
//  PC_W          64    width of pc_in / fault_pc
//  CNT_W         32    width of retired and cycle counters
//  MAX_CYCLES    4096  watchdog limit of RUN cycles (>=2)
//  DRAIN_CYCLES  2     cycles spent in DRAIN before STOP (>=1)
// PORTS
//  clk          in   1      processor clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      pulse: begin execution (honoured in IDLE only)
//  clear        in   1      pulse: leave STOP, return to IDLE (honoured in STOP only)
//  instr_valid  in   1      an instruction completes this cycle
//  status_in    in   2      status of that instruction: 0 AOK, 1 HLT, 2 ADR, 3 INS
//  pc_in        in   PC_W   PC of that instruction
//  commit_en    out  1      combinational write enable for PC/regfile/memory
//  status_out   out  2      sticky machine status
//  fault_pc     out  PC_W   PC of the first non-AOK instruction
//  retired_cnt  out  CNT_W  AOK instructions committed since start
//  cycle_cnt    out  CNT_W  cycles spent in RUN since start
//  timeout      out  1      watchdog expired (status_out stays AOK)
//  done         out  1      level, high in STOP
//  done_pulse   out  1      one-cycle pulse on entry to STOP
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE. status_out=0, fault_pc=0, retired_cnt=0, cycle_cnt=0,
//   timeout=0, done=0, done_pulse=0, commit_en=0. Reset mid-run aborts immediately, with no drain.
//  States: IDLE -> RUN -> DRAIN -> STOP -> IDLE.
//  IDLE: commit_en=0. start=1 -> RUN next cycle. Entry to RUN zeroes counters, status_out,
//   fault_pc and timeout.
//  RUN: commit_en = ~(instr_valid & status_in!=0); it is 1 on cycles with no instr_valid.
//   cycle_cnt +1 every RUN cycle.
//   On instr_valid & status_in==0, retired_cnt +1. Both counters saturate at all-ones.
//   On instr_valid & status_in!=0: latch status_out<=status_in and fault_pc<=pc_in, go to DRAIN.
//    The faulting instruction does not commit and is not counted.
//   Watchdog: if cycle_cnt==MAX_CYCLES-1 and no fault this cycle, set timeout=1 and go to DRAIN.
//    A fault on the same cycle wins: status is latched and timeout stays 0.
//  DRAIN: commit_en=0. status_in/instr_valid ignored; status_out frozen (first fault sticky).
//   An internal counter runs DRAIN_CYCLES cycles, then goes to STOP. done_pulse=1 for exactly
//   the first STOP cycle.
//  STOP: done=1, commit_en=0, all outputs held. clear=1 -> IDLE. Outputs keep their values until
//   the next start.
//  start outside IDLE and clear outside STOP are ignored. start and clear both high: only the
//   one matching the current state acts.
// STRUCTURE
//  Shared include/package y86_status_pkg: STAT_AOK=0, STAT_HLT=1, STAT_ADR=2, STAT_INS=3 and
//   the state encodings. The status-update block uses the same constants.
//  One sub-module, sat_counter (CNT_W, inc, clr, q; saturating), instantiated for retired_cnt
//   and cycle_cnt. The FSM, drain counter and capture registers are inline.
// TESTING
//  1 Reset mid-RUN (rst_n low 1 cycle after 5 AOK) -> IDLE; all outputs 0; commit_en=0.
//  2 start; 10 AOK instr_valid; then HLT at pc=0x40 -> commit_en=0 that cycle; status_out=1;
//    fault_pc=0x40; retired_cnt=10; done_pulse 1 cycle, DRAIN_CYCLES+1 cycles after the HLT.
//  3 ADR at pc=0x18, then INS on the next cycle -> status_out stays 2 and fault_pc stays 0x18.
//  4 MAX_CYCLES=16, only AOK -> timeout=1 after 16 RUN cycles; status_out=0; done asserts.
//    Repeat with INS on cycle 16 -> status_out=3, timeout=0.
//  5 In STOP pulse start -> no change; pulse clear -> IDLE; start -> counters restart at 0.
//  6 CNT_W=4, 20 AOK -> retired_cnt saturates at 15 and cycle_cnt at 15.

Source files
------------

// File: rtl/y86_status_pkg.sv
// Shared Y86 status codes and halt-controller state encodings.
// Also used by the SEQ status-update logic.
package y86_status_pkg;

  localparam int unsigned STAT_W  = 2;
  localparam int unsigned STATE_W = 2;

  localparam logic [STAT_W-1:0] STAT_AOK = 2'd0;
  localparam logic [STAT_W-1:0] STAT_HLT = 2'd1;
  localparam logic [STAT_W-1:0] STAT_ADR = 2'd2;
  localparam logic [STAT_W-1:0] STAT_INS = 2'd3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

  function automatic logic is_fault(input logic [STAT_W-1:0] stat);
    return stat != STAT_AOK;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_halt_controller.sv
// SEQ halt controller: gates commits while status is AOK, freezes on the first
// fault or watchdog expiry, captures the faulting PC and reports done.
module seq_halt_controller
  import y86_status_pkg::*;
#(
  parameter int unsigned PC_W         = 64,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 4096,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              instr_valid,
  input  logic [STAT_W-1:0] status_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic              commit_en,
  output logic [STAT_W-1:0] status_out,
  output logic [PC_W-1:0]   fault_pc,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              timeout,
  output logic              done,
  output logic              done_pulse
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam int unsigned CMP_W   = (CNT_W > 32) ? CNT_W : 32;

  logic [STATE_W-1:0] state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt, drain_d;
  logic [STAT_W-1:0]  status_d;
  logic [PC_W-1:0]    fault_pc_d;
  logic               timeout_d;
  logic               done_d;
  logic               done_pulse_d;
  logic               cnt_clr;
  logic               retire_inc;
  logic               cycle_inc;
  logic               fault_now;
  logic               wd_hit;

  assign fault_now = instr_valid && is_fault(status_in);
  // Compare in a width wide enough for both the counter and the limit.
  assign wd_hit    = (CMP_W'(cycle_cnt) == CMP_W'(MAX_CYCLES - 1));

  sat_counter #(.CNT_W(CNT_W)) u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (retire_inc),
    .q     (retired_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cycle_inc),
    .q     (cycle_cnt)
  );

  // Next-state, capture and commit-enable logic.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_cnt;
    status_d   = status_out;
    fault_pc_d = fault_pc;
    timeout_d  = timeout;
    cnt_clr    = 1'b0;
    retire_inc = 1'b0;
    cycle_inc  = 1'b0;
    commit_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          cnt_clr    = 1'b1;
          status_d   = STAT_AOK;
          fault_pc_d = '0;
          timeout_d  = 1'b0;
        end
      end
      ST_RUN: begin
        cycle_inc = 1'b1;
        commit_en = !fault_now;
        drain_d   = '0;
        if (fault_now) begin
          status_d   = status_in;
          fault_pc_d = pc_in;
          state_d    = ST_DRAIN;
        end else begin
          retire_inc = instr_valid;
          if (wd_hit) begin
            timeout_d = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_STOP;
        end else begin
          drain_d = drain_cnt + DRAIN_W'(1);
        end
      end
      ST_STOP: begin
        if (clear) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d       = (state_d == ST_STOP);
    done_pulse_d = (state_q == ST_DRAIN) && (state_d == ST_STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      drain_cnt  <= '0;
      status_out <= STAT_AOK;
      fault_pc   <= '0;
      timeout    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_cnt  <= drain_d;
      status_out <= status_d;
      fault_pc   <= fault_pc_d;
      timeout    <= timeout_d;
      done       <= done_d;
      done_pulse <= done_pulse_d;
    end
  end

endmodule
